// File: rtl/multiplier_array_pipe_if.sv
// Operand/product handshake bundle for the pipelined array multiplier.
// The producer drives operands on the in_* side and the consumer drives out_ready.
interface multiplier_array_pipe_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sgn;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;

    // Environment side: supplies operands and accepts products.
    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, y
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/multiplier_array_pipe.sv
// Pipelined array multiplier. An input register stage is followed by
// WIDTH/ROWS_PER_STAGE accumulation stages, each adding ROWS_PER_STAGE
// shifted partial-product rows. Signed mode sign-extends the multiplicand
// and subtracts the row selected by the multiplier MSB. The whole pipe
// stalls together when the output holds a product nobody accepts.
module multiplier_array_pipe #(
    parameter int WIDTH          = 4,
    parameter int ROWS_PER_STAGE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multiplier_array_pipe_if.slave bus_if
);
    localparam int STAGES = WIDTH / ROWS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;

    // Stage 0 is the input register; stage STAGES drives the outputs.
    logic [WIDTH-1:0] a_q     [0:STAGES];
    logic [WIDTH-1:0] b_q     [0:STAGES];
    logic             sgn_q   [0:STAGES];
    logic             valid_q [0:STAGES];
    logic [PW-1:0]    sum_q   [0:STAGES];

    logic [WIDTH-1:0] a_d     [0:STAGES];
    logic [WIDTH-1:0] b_d     [0:STAGES];
    logic             sgn_d   [0:STAGES];
    logic             valid_d [0:STAGES];
    logic [PW-1:0]    sum_d   [0:STAGES];

    logic adv;

    // Adds partial-product row idx (selected by a[idx]) to acc, modulo 2^PW.
    // In signed mode the MSB row has negative weight, so it is subtracted.
    function automatic logic [PW-1:0] add_row(
        input logic [PW-1:0]    acc,
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v,
        input logic             s_v,
        input int               idx
    );
        logic [PW-1:0]    bext;
        logic [PW-1:0]    row;
        logic [WIDTH-1:0] a_sh;
        bext = {{WIDTH{s_v & b_v[WIDTH-1]}}, b_v};
        a_sh = a_v >> idx;
        row  = a_sh[0] ? (bext << idx) : '0;
        if (s_v && (idx == WIDTH - 1))
            return acc - row;
        else
            return acc + row;
    endfunction

    // Global stall: move only when the output slot is empty or being drained.
    assign adv              = bus_if.out_ready | ~valid_q[STAGES];
    assign bus_if.in_ready  = adv;
    assign bus_if.out_valid = valid_q[STAGES];
    assign bus_if.y         = sum_q[STAGES];

    // Next-state for every stage: capture inputs, then accumulate rows stage by stage.
    always_comb begin
        // NOTE: every _d element is assigned on every pass, so no latch can be inferred.
        a_d[0]     = bus_if.a;
        b_d[0]     = bus_if.b;
        sgn_d[0]   = bus_if.sgn;
        valid_d[0] = bus_if.in_valid;
        sum_d[0]   = '0;
        for (int k = 1; k <= STAGES; k++) begin
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            sgn_d[k]   = sgn_q[k-1];
            valid_d[k] = valid_q[k-1];
            sum_d[k]   = sum_q[k-1];
            for (int r = 0; r < ROWS_PER_STAGE; r++) begin
                sum_d[k] = add_row(sum_d[k], a_q[k-1], b_q[k-1], sgn_q[k-1],
                                   (k - 1) * ROWS_PER_STAGE + r);
            end
        end
    end

    // Pipeline registers: cleared by reset, loaded together when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage arrays are ordinary registers, not RAM, so they are
            // all cleared here; reset discards in-flight products and zeroes y.
            for (int k = 0; k <= STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sgn_q[k]   <= 1'b0;
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            for (int k = 0; k <= STAGES; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sgn_q[k]   <= sgn_d[k];
                valid_q[k] <= valid_d[k];
                sum_q[k]   <= sum_d[k];
            end
        end
    end
endmodule

// File: tb/tb_multiplier_array_pipe.sv
// Directed bench for multiplier_array_pipe: one WIDTH=4 instance for the
// handshake scenarios and four WIDTH=8 instances for the row-grouping sweep.
module tb_multiplier_array_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=4 instance ----------------
    multiplier_array_pipe_if #(.WIDTH(4)) m_if ();
    multiplier_array_pipe #(.WIDTH(4), .ROWS_PER_STAGE(1)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (m_if.slave)
    );

    // ---------------- WIDTH=8 sweep instances ----------------
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        sgn8;
    logic        iv8;
    logic        ov8 [4];
    logic [15:0] y8  [4];

    multiplier_array_pipe_if #(.WIDTH(8)) w_if0 ();
    multiplier_array_pipe_if #(.WIDTH(8)) w_if1 ();
    multiplier_array_pipe_if #(.WIDTH(8)) w_if2 ();
    multiplier_array_pipe_if #(.WIDTH(8)) w_if3 ();

    assign w_if0.a = a8; assign w_if0.b = b8; assign w_if0.sgn = sgn8;
    assign w_if0.in_valid = iv8; assign w_if0.out_ready = 1'b1;
    assign w_if1.a = a8; assign w_if1.b = b8; assign w_if1.sgn = sgn8;
    assign w_if1.in_valid = iv8; assign w_if1.out_ready = 1'b1;
    assign w_if2.a = a8; assign w_if2.b = b8; assign w_if2.sgn = sgn8;
    assign w_if2.in_valid = iv8; assign w_if2.out_ready = 1'b1;
    assign w_if3.a = a8; assign w_if3.b = b8; assign w_if3.sgn = sgn8;
    assign w_if3.in_valid = iv8; assign w_if3.out_ready = 1'b1;

    assign ov8[0] = w_if0.out_valid; assign y8[0] = w_if0.y;
    assign ov8[1] = w_if1.out_valid; assign y8[1] = w_if1.y;
    assign ov8[2] = w_if2.out_valid; assign y8[2] = w_if2.y;
    assign ov8[3] = w_if3.out_valid; assign y8[3] = w_if3.y;

    multiplier_array_pipe #(.WIDTH(8), .ROWS_PER_STAGE(1)) u_w8_r1 (
        .clk(clk), .rst_n(rst_n), .bus_if(w_if0.slave));
    multiplier_array_pipe #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_w8_r2 (
        .clk(clk), .rst_n(rst_n), .bus_if(w_if1.slave));
    multiplier_array_pipe #(.WIDTH(8), .ROWS_PER_STAGE(4)) u_w8_r4 (
        .clk(clk), .rst_n(rst_n), .bus_if(w_if2.slave));
    multiplier_array_pipe #(.WIDTH(8), .ROWS_PER_STAGE(8)) u_w8_r8 (
        .clk(clk), .rst_n(rst_n), .bus_if(w_if3.slave));

    // Independent reference for the 8-bit sweep: plain integer multiply.
    function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b,
                                             input logic s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return 16'(sa * sb);
        end
        return 16'({8'h00, a} * {8'h00, b});
    endfunction

    // ---------------- Tests ----------------
    task automatic test_reset;
        rst_n          = 1'b0;
        m_if.in_valid  = 1'b0;
        m_if.a         = '0;
        m_if.b         = '0;
        m_if.sgn       = 1'b0;
        m_if.out_ready = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_reset out_valid got %b want 0", m_if.out_valid);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (m_if.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_out_valid cyc %0d got %b want 0", c, m_if.out_valid);
            end
            n_checks++;
            if (m_if.y !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_idle_y cyc %0d got %h want 00", c, m_if.y);
            end
            n_checks++;
            if (m_if.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle_in_ready cyc %0d got %b want 1", c, m_if.in_ready);
            end
        end
    endtask

    // Single beat; reports edges from acceptance to first out_valid, product and valid count.
    task automatic single_beat4(input logic [3:0] a, input logic [3:0] b, input logic s,
                                output int first_j, output logic [7:0] got, output int n_valid);
        first_j = -1;
        got     = '0;
        n_valid = 0;
        m_if.in_valid = 1'b1;
        m_if.a = a; m_if.b = b; m_if.sgn = s;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) m_if.in_valid = 1'b0;
            if (m_if.out_valid === 1'b1) begin
                n_valid++;
                if (first_j < 0) begin
                    first_j = j;
                    got     = m_if.y;
                end
            end
        end
    endtask

    task automatic test_unsigned_latency;
        int         first_j;
        int         n_valid;
        logic [7:0] got;
        n_checks++;
        if (m_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL unsigned_in_ready got %b want 1", m_if.in_ready);
        end
        single_beat4(4'd13, 4'd11, 1'b0, first_j, got, n_valid);
        n_checks++;
        if (first_j != 4) begin
            n_fail++;
            $display("FAIL unsigned_latency got %0d edges want 4", first_j);
        end
        n_checks++;
        if (got !== 8'h8F) begin
            n_fail++;
            $display("FAIL unsigned_product got %h want 8f", got);
        end
        n_checks++;
        if (n_valid != 1) begin
            n_fail++;
            $display("FAIL unsigned_valid_cycles got %0d want 1", n_valid);
        end
    endtask

    task automatic test_signed_corners;
        logic [3:0] va  [4] = '{4'h8, 4'h8, 4'hF, 4'h7};
        logic [3:0] vb  [4] = '{4'h8, 4'h7, 4'hF, 4'hD};
        logic [7:0] exp [4] = '{8'h40, 8'hC8, 8'h01, 8'hEB};
        int n_seen  = 0;
        int first_c = -1;
        int last_c  = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 4) begin
                m_if.in_valid = 1'b1;
                m_if.a = va[c]; m_if.b = vb[c]; m_if.sgn = 1'b1;
            end else begin
                m_if.in_valid = 1'b0;
            end
            @(negedge clk);
            if (m_if.out_valid === 1'b1) begin
                if (n_seen < 4) begin
                    n_checks++;
                    if (m_if.y !== exp[n_seen]) begin
                        n_fail++;
                        $display("FAIL signed_product idx %0d got %h want %h",
                                 n_seen, m_if.y, exp[n_seen]);
                    end
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                n_seen++;
            end
        end
        n_checks++;
        if (n_seen != 4) begin
            n_fail++;
            $display("FAIL signed_count got %0d want 4", n_seen);
        end
        n_checks++;
        if (last_c - first_c != 3) begin
            n_fail++;
            $display("FAIL signed_consecutive got span %0d want 3", last_c - first_c);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q [$];
        logic [7:0] want;
        logic [7:0] prev_y     = '0;
        logic       prev_ov    = 1'b0;
        logic       prev_stall = 1'b0;
        int         sent = 0;
        int         recv = 0;
        for (int cyc = 0; cyc < 500 && recv < 16; cyc++) begin
            m_if.in_valid  = (sent < 16);
            m_if.a         = 4'(sent);
            m_if.b         = 4'(sent);
            m_if.sgn       = 1'b0;
            m_if.out_ready = 1'($urandom_range(1, 0));
            #1;
            if (prev_stall) begin
                n_checks++;
                if (m_if.out_valid !== prev_ov) begin
                    n_fail++;
                    $display("FAIL bp_stall_valid cyc %0d got %b want %b", cyc, m_if.out_valid, prev_ov);
                end
                n_checks++;
                if (m_if.y !== prev_y) begin
                    n_fail++;
                    $display("FAIL bp_stall_y cyc %0d got %h want %h", cyc, m_if.y, prev_y);
                end
            end
            n_checks++;
            if (m_if.in_ready !== !(m_if.out_valid && !m_if.out_ready)) begin
                n_fail++;
                $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, m_if.in_ready,
                         !(m_if.out_valid && !m_if.out_ready));
            end
            if (m_if.in_valid && m_if.in_ready) begin
                exp_q.push_back(8'(sent * sent));
                sent++;
            end
            if (m_if.out_valid && m_if.out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_checks++;
                if (m_if.y !== want) begin
                    n_fail++;
                    $display("FAIL bp_product idx %0d got %h want %h", recv, m_if.y, want);
                end
                recv++;
            end
            prev_stall = m_if.out_valid && !m_if.out_ready;
            prev_ov    = m_if.out_valid;
            prev_y     = m_if.y;
            @(negedge clk);
        end
        n_checks++;
        if (recv != 16) begin
            n_fail++;
            $display("FAIL bp_received got %0d want 16", recv);
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (m_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_duplicate got out_valid %b want 0", m_if.out_valid);
        end
    endtask

    // One beat into all four 8-bit instances; checks product and optionally latency.
    task automatic sweep_vec(input logic [7:0] a, input logic [7:0] b, input logic s,
                             input logic [15:0] exp, input bit check_lat);
        int          exp_lat [4] = '{9, 5, 3, 2};
        int          lat     [4] = '{-1, -1, -1, -1};
        logic [15:0] got     [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
        a8 = a; b8 = b; sgn8 = s; iv8 = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 0) iv8 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (ov8[k] === 1'b1 && lat[k] < 0) begin
                    lat[k] = j + 1;
                    got[k] = y8[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (lat[k] < 0 || got[k] !== exp) begin
                n_fail++;
                $display("FAIL sweep_product inst %0d a %h b %h sgn %b got %h want %h",
                         k, a, b, s, got[k], exp);
            end
            if (check_lat) begin
                n_checks++;
                if (lat[k] != exp_lat[k]) begin
                    n_fail++;
                    $display("FAIL sweep_latency inst %0d got %0d want %0d", k, lat[k], exp_lat[k]);
                end
            end
        end
    endtask

    task automatic test_param_sweep;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        sweep_vec(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        sweep_vec(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        sweep_vec(8'hFF, 8'h05, 1'b1, 16'hFFFB, 1'b0);
        sweep_vec(8'hFF, 8'h05, 1'b0, 16'h04FB, 1'b0);
        sweep_vec(8'd200, 8'd3, 1'b0, 16'h0258, 1'b0);
        sweep_vec(8'h9C, 8'h32, 1'b1, 16'hEC78, 1'b0);
        sweep_vec(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rs = 1'($urandom_range(1, 0));
            sweep_vec(ra, rb, rs, ref_mul8(ra, rb, rs), 1'b0);
        end
    endtask

    task automatic test_midstream_reset;
        logic [3:0] va [3] = '{4'd3, 4'd2, 4'd9};
        logic [3:0] vb [3] = '{4'd5, 4'd7, 4'd9};
        logic       seen = 1'b0;
        int         first_j;
        int         n_valid;
        logic [7:0] got;
        m_if.out_ready = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (c < 3) begin
                m_if.in_valid = 1'b1;
                m_if.a = va[c]; m_if.b = vb[c]; m_if.sgn = 1'b0;
            end else begin
                m_if.in_valid = 1'b0;
            end
            @(negedge clk);
            if (m_if.out_valid === 1'b1) seen = 1'b1;
        end
        m_if.in_valid = 1'b0;
        n_checks++;
        if (m_if.y !== 8'h0F) begin
            n_fail++;
            $display("FAIL mrst_first_product got %h want 0f", m_if.y);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_out_valid got %b want 0", m_if.out_valid);
        end
        n_checks++;
        if (m_if.y !== 8'h00) begin
            n_fail++;
            $display("FAIL mrst_y got %h want 00", m_if.y);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (m_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mrst_in_ready got %b want 1", m_if.in_ready);
        end
        n_valid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m_if.out_valid === 1'b1) n_valid++;
        end
        n_checks++;
        if (n_valid != 0) begin
            n_fail++;
            $display("FAIL mrst_stale got %0d valid cycles want 0", n_valid);
        end
        single_beat4(4'd6, 4'd7, 1'b0, first_j, got, n_valid);
        n_checks++;
        if (first_j != 4) begin
            n_fail++;
            $display("FAIL mrst_latency got %0d edges want 4", first_j);
        end
        n_checks++;
        if (got !== 8'h2A) begin
            n_fail++;
            $display("FAIL mrst_product got %h want 2a", got);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned_latency();
        test_signed_corners();
        test_back_to_back();
        test_param_sweep();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the scenarios above need a few thousand cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multiplier_array_pipe.md
# multiplier_array_pipe

Parametrised pipelined array multiplier with valid/ready handshake, selectable signed/unsigned operation and configurable partial-product rows per stage. Successor to the fixed 4-bit, one-row-per-stage, free-running array multiplier. Sits in datapaths that need a throughput-1 multiplier with back-pressure and a known, parameter-derived latency.

## Interface
- WIDTH, 4: operand width in bits; must be at least 2.
- ROWS_PER_STAGE, 1: partial-product rows accumulated per pipeline stage; must divide WIDTH.
- Derived: STAGES = WIDTH/ROWS_PER_STAGE; LATENCY = STAGES+1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, sgn valid this cycle.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  multiplier operand.
- b  input  WIDTH  multiplicand operand.
- sgn  input  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  output  1  y holds a completed product.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  2*WIDTH  product.

## Operation
- Structure: input register stage (stage 0) plus STAGES accumulation stages. Each stage holds a, b, sgn, the partial sum (2*WIDTH bits) and a valid bit.
- Stage 0 captures a, b, sgn and in_valid. Partial sum starts at 0.
- Stage k (1..STAGES) adds rows i = (k-1)*ROWS_PER_STAGE … k*ROWS_PER_STAGE-1 to the partial sum from stage k-1.
- Row i: if a[i] = 1, the row is bext << i; otherwise the row is 0.
  - bext is b zero-extended to 2*WIDTH when sgn=0, and sign-extended when sgn=1.
- Signed correction: when sgn=1, row WIDTH-1 is subtracted instead of added, because a's MSB carries weight -2^(WIDTH-1).
- All arithmetic is modulo 2^(2*WIDTH). Carries out of bit 2*WIDTH-1 are discarded.
- y is the final-stage partial sum. out_valid is the final-stage valid bit.
- Pipeline advance: adv = out_ready OR NOT out_valid.
  - All stages load together when adv=1 and hold when adv=0 (global stall).
  - Bubbles are not collapsed.
- in_ready = adv. Transfer in occurs when in_valid AND in_ready. Transfer out occurs when out_valid AND out_ready.
- Invalid stages still compute, but their data is don't-care. Only valid bits gate visibility.
- Reset (rst_n low, any time, including mid-stream):
  - All valid bits clear immediately and all data registers go to 0.
  - out_valid=0, y=0; in_ready=1 as soon as reset releases.
  - In-flight products are discarded.

## Timing
- Latency: an operand set accepted at rising edge t, with no stalls, appears with out_valid=1 after edge t+STAGES. That is LATENCY = STAGES+1 register stages.
- Throughput: one product per cycle while out_ready=1.
- Each stall cycle (out_valid=1, out_ready=0) adds exactly one cycle to every in-flight product's latency.
- While stalled, y and out_valid hold stable.
- in_ready is combinational from out_ready and out_valid. No other combinational input-to-output path exists.
- sgn is per-transaction: mixed signed and unsigned operand sets may be issued back-to-back.
- Each stage's critical path is ROWS_PER_STAGE adders of 2*WIDTH bits.

## Test plan
- Reset and idle:
  - Stimulus: rst_n=0, then release with in_valid=0.
  - Required: out_valid=0, y=0, in_ready=1 for 10 cycles.
- Unsigned latency (WIDTH=4, ROWS_PER_STAGE=1):
  - Stimulus: a=13, b=11, sgn=0, single beat, out_ready=1.
  - Required: y=143 (8'h8F) with out_valid=1 exactly 4 edges after acceptance, for exactly one cycle.
- Signed corners (WIDTH=4):
  - Stimulus, back-to-back with sgn=1: (-8)×(-8), (-8)×7, (-1)×(-1), 7×(-3).
  - Required: y = 8'h40, 8'hC8, 8'h01, 8'hEB on consecutive cycles.
- Back-pressure:
  - Stimulus: stream 0×0 … 15×15 (unsigned) with out_ready toggled pseudo-randomly.
  - Required: no loss or duplication, y in order, y and out_valid stable while stalled, in_ready=0 only while stalled.
- Parameter sweep:
  - Stimulus: WIDTH=8 with ROWS_PER_STAGE = 1, 2, 4, 8.
  - Required: latency = 9, 5, 3, 2 respectively.
  - Required: 255×255 unsigned = 16'hFE01; (-128)×(-128) signed = 16'h4000; random mixed-sgn products match a reference model.
- Mid-stream reset:
  - Stimulus: assert rst_n low while 3 products are in flight, then release.
  - Required: out_valid=0 and y=0 immediately; no stale product emerges afterward; the next accepted operand set has normal latency.
